ps2_message_buffer: RTL and testbench
=====================================

Name: ps2_message_buffer

Overview:
- Sits between the PS/2 scan-to-ASCII stage and the GPIO message transmitter.
- Collects ASCII keystrokes into a fixed-width text message and applies delete-key editing.
- On a send request, holds the message stable and drives the transmitter's data-ready level until the transmitter reports done. It then clears for the next message.
- Replaces the direct, unbuffered message_out register in the top level.

Parameters:
- MSG_CHARS, 16, characters per message; message width = 8*MSG_CHARS.
- DEL_CODE, 8'd127, ASCII code treated as backspace/delete.
- TIMEOUT_CYCLES, 250_000_000, clock cycles to wait for tx_done before aborting (5 s at 50 MHz).
- TO_W, 28, width of the timeout counter.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  keystroke-present level/strobe from the PS/2 interface, not necessarily one cycle wide.
- key_ascii  in  8  ASCII code accompanying key_valid.
- send  in  1  send request, level; acted on at its rising edge.
- tx_done  in  1  done level from the transmitter; asynchronous (slow-clock domain).
- message_out  out  8*MSG_CHARS  packed message; char 0 in bits [8*MSG_CHARS-1 -: 8]; unused bytes 0x00.
- msg_len  out  5  number of valid characters, 0..MSG_CHARS.
- tx_req  out  1  data-ready level to the transmitter.
- full  out  1  msg_len == MSG_CHARS.
- overflow  out  1  one-cycle pulse: a printable key was dropped because the buffer was full.
- tx_error  out  1  one-cycle pulse: the send timed out.

Behaviour:
- **Reset (synchronous, clock rising edge):**
  - state = EDIT; message_out = 0, msg_len = 0, tx_req = 0, overflow = 0, tx_error = 0.
  - Edge-detect history registers and sync flops = 0; timeout counter = 0.
  - Reset mid-SEND abandons the send immediately; tx_req is low on the next cycle.
- **Input conditioning:**
  - key_valid and send: registered once, then rising-edge detected, giving key_evt and send_evt. Event latency is 2 cycles from the input edge.
  - tx_done: 2-flop synchronizer, then rising-edge detect, giving done_evt.
- **State EDIT:**
  - send_evt with msg_len > 0: go to SEND, tx_req = 1 on the next cycle, clear the timeout counter.
  - send_evt with msg_len == 0: ignored; stay in EDIT.
  - send_evt and key_evt in the same cycle: send wins and the key is discarded. No overflow pulse.
  - key_evt, key_ascii == DEL_CODE:
    - msg_len > 0: msg_len decrements and the byte at index msg_len-1 becomes 0x00.
    - msg_len == 0: no-op.
  - key_evt, any other code:
    - not full: write the byte at index msg_len, then msg_len increments.
    - full: buffer unchanged; overflow pulses for 1 cycle.
  - key_ascii is sampled in the same cycle key_evt is asserted.
- **State SEND:**
  - message_out and msg_len are frozen; key_evt and send_evt are ignored silently.
  - The timeout counter increments every cycle.
  - done_evt: tx_req = 0, message_out = 0, msg_len = 0, go to EDIT.
  - Counter reaches TIMEOUT_CYCLES-1 without done_evt: tx_req = 0, tx_error pulses 1 cycle, go to EDIT with the buffer retained so it can be resent.
  - done_evt and timeout in the same cycle: done wins; no tx_error.
- **Outputs:** all outputs are registered. full is combinational from the registered msg_len.
- **Byte index arithmetic:** msg_len is 5 bits, with no wrap beyond MSG_CHARS; the full check is done before the increment.

Decomposition:
- Shared package `msg_pkg` holds:
  - state enum {EDIT, SEND};
  - constants ASCII_DEL = 8'd127, ASCII_SPACE = 8'd32, CHAR_W = 8.
- One natural sub-module, `edge_sync`, reused three times. Ports: clock, reset, async_in, SYNC_STAGES parameter (2 for tx_done, 1 for the others), rise pulse out.

Test Plan:
- Reset, then keys 'h'(104) and 'i'(105), each held high 5 cycles:
  - msg_len = 2; message_out[127:112] = 16'h6869; remaining bytes 0; tx_req = 0.
- Type "abc", then DEL (127), then 'd':
  - msg_len = 3; top 24 bits = 24'h616264.
  - A DEL issued at msg_len == 0 leaves everything 0.
- Type 17 'a' keys:
  - after the 16th, full = 1 and message_out = {16{8'h61}};
  - the 17th produces exactly one overflow pulse with the buffer unchanged.
- Type "ok", pulse send:
  - tx_req rises 3 cycles after the send edge.
  - Keys typed while tx_req = 1 do not change message_out.
  - Raise tx_done: within 4 cycles tx_req = 0, msg_len = 0, message_out = 0.
- With TIMEOUT_CYCLES = 20, send "x" and never assert tx_done:
  - tx_req stays high 20 cycles, then drops; tx_error pulses once; msg_len = 1 retained.
  - A second send re-asserts tx_req.
- Assert reset for 1 cycle while in SEND:
  - next cycle tx_req = 0, msg_len = 0, state EDIT.
  - A send with an empty buffer afterwards leaves tx_req = 0.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types and constants for the PS/2 message buffer.
package msg_pkg;

  typedef enum logic {
    EDIT,
    SEND
  } state_t;

  localparam int unsigned CHAR_W      = 8;
  localparam logic [7:0]  ASCII_DEL   = 8'd127;
  localparam logic [7:0]  ASCII_SPACE = 8'd32;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes a level into the clock domain and emits a registered
// one-cycle pulse on its rising edge.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // Sync chain, edge history and registered rise pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/ps2_message_buffer.sv
// Collects ASCII keystrokes into a fixed-width message with delete editing,
// then holds it and handshakes with the GPIO message transmitter.
module ps2_message_buffer
  import msg_pkg::*;
#(
  parameter int unsigned MSG_CHARS      = 16,
  parameter logic [7:0]  DEL_CODE       = ASCII_DEL,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned TO_W           = 28
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        key_valid,
  input  logic [7:0]                  key_ascii,
  input  logic                        send,
  input  logic                        tx_done,
  output logic [CHAR_W*MSG_CHARS-1:0] message_out,
  output logic [4:0]                  msg_len,
  output logic                        tx_req,
  output logic                        full,
  output logic                        overflow,
  output logic                        tx_error
);

  localparam int unsigned MW    = CHAR_W * MSG_CHARS;
  localparam int unsigned LEN_W = 5;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MSG_CHARS);

  logic key_evt, send_evt, done_evt;

  edge_sync #(.SYNC_STAGES(1)) u_key_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (key_valid),
    .rise     (key_evt)
  );

  edge_sync #(.SYNC_STAGES(1)) u_send_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (send),
    .rise     (send_evt)
  );

  // tx_done comes from the transmitter's slow clock domain.
  edge_sync #(.SYNC_STAGES(2)) u_done_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (tx_done),
    .rise     (done_evt)
  );

  state_t           state_q, state_d;
  logic [MW-1:0]    msg_q, msg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             tx_req_q, tx_req_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             is_full;

  assign is_full = (len_q == LEN_FULL);

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= EDIT;
      msg_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      tx_req_q <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      tx_req_q <= tx_req_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Editing, send handshake and timeout next-state logic.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      EDIT: begin
        if (send_evt) begin
          // A coincident key is discarded; an empty message is never sent.
          if (len_q != '0) begin
            state_d = SEND;
            cnt_d   = '0;
          end
        end else if (key_evt) begin
          if (key_ascii == DEL_CODE) begin
            if (len_q != '0) begin
              for (int unsigned i = 0; i < MSG_CHARS; i++) begin
                if (LEN_W'(i) == len_q - 5'd1) begin
                  msg_d[CHAR_W*(MSG_CHARS-1-i) +: CHAR_W] = '0;
                end
              end
              len_d = len_q - 5'd1;
            end
          end else if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            for (int unsigned i = 0; i < MSG_CHARS; i++) begin
              if (LEN_W'(i) == len_q) begin
                msg_d[CHAR_W*(MSG_CHARS-1-i) +: CHAR_W] = key_ascii;
              end
            end
            len_d = len_q + 5'd1;
          end
        end
      end
      SEND: begin
        cnt_d = cnt_q + 1'b1;
        if (done_evt) begin
          state_d = EDIT;
          msg_d   = '0;
          len_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          // Keep the buffer so the user can resend it.
          state_d = EDIT;
          err_d   = 1'b1;
        end
      end
      default: state_d = EDIT;
    endcase
    tx_req_d = (state_d == SEND);
  end

  assign message_out = msg_q;
  assign msg_len     = len_q;
  assign tx_req      = tx_req_q;
  assign full        = is_full;
  assign overflow    = ovf_q;
  assign tx_error    = err_q;

endmodule

// File: tb/tb_ps2_message_buffer.sv
// Scoreboard-based bench for ps2_message_buffer.
module tb_ps2_message_buffer;

  localparam int unsigned MC = 16;
  localparam int unsigned TO = 20;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           key_valid = 1'b0;
  logic [7:0]     key_ascii = 8'd0;
  logic           send = 1'b0;
  logic           tx_done = 1'b0;
  logic [8*MC-1:0] message_out;
  logic [4:0]     msg_len;
  logic           tx_req, full, overflow, tx_error;

  ps2_message_buffer #(
    .MSG_CHARS      (MC),
    .DEL_CODE       (8'd127),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (28)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_ascii   (key_ascii),
    .send        (send),
    .tx_done     (tx_done),
    .message_out (message_out),
    .msg_len     (msg_len),
    .tx_req      (tx_req),
    .full        (full),
    .overflow    (overflow),
    .tx_error    (tx_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  int err_cnt = 0;

  always @(negedge clock) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (tx_error === 1'b1) err_cnt++;
  end

  typedef struct packed {
    logic [8*MC-1:0] msg;
    logic [4:0]      len;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_buf [MC];
  int         m_len;

  function automatic logic [8*MC-1:0] m_pack();
    logic [8*MC-1:0] r;
    r = '0;
    for (int i = 0; i < MC; i++) r[8*(MC-1-i) +: 8] = m_buf[i];
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < MC; i++) m_buf[i] = 8'd0;
    m_len = 0;
  endfunction

  // Editing model: applies one keystroke and queues the expected result.
  function automatic void model_key(input logic [7:0] a);
    exp_t e;
    if (a == 8'd127) begin
      if (m_len > 0) begin
        m_len--;
        m_buf[m_len] = 8'd0;
      end
    end else if (m_len < MC) begin
      m_buf[m_len] = a;
      m_len++;
    end
    e.msg = m_pack();
    e.len = 5'(m_len);
    sb.push_back(e);
  endfunction

  task automatic type_key(input logic [7:0] a);
    @(negedge clock);
    key_ascii = a;
    key_valid = 1'b1;
    repeat (5) @(negedge clock);
    key_valid = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (message_out !== '0 || msg_len !== 5'd0) begin
      errors++;
      $display("FAIL reset_buf: msg=%h len=%0d, want 0/0", message_out, msg_len);
    end
    checks++;
    if (tx_req !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: tx_req=%b full=%b, want 0/0", tx_req, full);
    end
    checks++;
    if (overflow !== 1'b0 || tx_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse: ovf=%b err=%b, want 0/0", overflow, tx_error);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_hi();
    exp_t e;
    logic [7:0] keys [2];
    do_reset();
    keys[0] = 8'd104;
    keys[1] = 8'd105;
    for (int k = 0; k < 2; k++) begin
      type_key(keys[k]);
      model_key(keys[k]);
      e = sb.pop_front();
      checks++;
      if (message_out !== e.msg || msg_len !== e.len) begin
        errors++;
        $display("FAIL hi_key%0d: msg=%h len=%0d, want msg=%h len=%0d",
                 k, message_out, msg_len, e.msg, e.len);
      end
    end
    checks++;
    if (message_out[127:112] !== 16'h6869 || message_out[111:0] !== '0) begin
      errors++;
      $display("FAIL hi_bytes: msg=%h, want 6869 followed by zeros", message_out);
    end
    checks++;
    if (tx_req !== 1'b0) begin
      errors++;
      $display("FAIL hi_txreq: tx_req=%b, want 0", tx_req);
    end
  endtask

  task automatic test_delete();
    exp_t e;
    logic [7:0] keys [5];
    do_reset();
    type_key(8'd127);
    model_key(8'd127);
    e = sb.pop_front();
    checks++;
    if (message_out !== e.msg || msg_len !== e.len || message_out !== '0) begin
      errors++;
      $display("FAIL del_empty: msg=%h len=%0d, want 0/0", message_out, msg_len);
    end
    keys[0] = 8'h61; keys[1] = 8'h62; keys[2] = 8'h63;
    keys[3] = 8'd127; keys[4] = 8'h64;
    for (int k = 0; k < 5; k++) begin
      type_key(keys[k]);
      model_key(keys[k]);
      e = sb.pop_front();
      checks++;
      if (message_out !== e.msg || msg_len !== e.len) begin
        errors++;
        $display("FAIL del_key%0d: msg=%h len=%0d, want msg=%h len=%0d",
                 k, message_out, msg_len, e.msg, e.len);
      end
    end
    checks++;
    if (message_out[127:104] !== 24'h616264 || msg_len !== 5'd3) begin
      errors++;
      $display("FAIL del_final: top=%h len=%0d, want 616264/3",
               message_out[127:104], msg_len);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int o0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      type_key(8'h61);
      model_key(8'h61);
      e = sb.pop_front();
      checks++;
      if (message_out !== e.msg || msg_len !== e.len) begin
        errors++;
        $display("FAIL fill_key%0d: msg=%h len=%0d, want msg=%h len=%0d",
                 k, message_out, msg_len, e.msg, e.len);
      end
    end
    checks++;
    if (full !== 1'b1 || message_out !== {16{8'h61}}) begin
      errors++;
      $display("FAIL full_flag: full=%b msg=%h, want 1 and all 61", full, message_out);
    end
    o0 = ovf_cnt;
    type_key(8'h61);
    model_key(8'h61);
    e = sb.pop_front();
    checks++;
    if (message_out !== e.msg || msg_len !== e.len) begin
      errors++;
      $display("FAIL ovf_buf: msg=%h len=%0d, want msg=%h len=%0d",
               message_out, msg_len, e.msg, e.len);
    end
    checks++;
    if (ovf_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL ovf_pulse: pulses=%0d, want 1", ovf_cnt - o0);
    end
  endtask

  task automatic test_send_done();
    exp_t e;
    int e0;
    do_reset();
    e0 = err_cnt;
    type_key(8'h6f); model_key(8'h6f);
    type_key(8'h6b); model_key(8'h6b);
    void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if (message_out !== e.msg || msg_len !== e.len) begin
      errors++;
      $display("FAIL ok_buf: msg=%h len=%0d, want msg=%h len=%0d",
               message_out, msg_len, e.msg, e.len);
    end
    @(negedge clock);
    send = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (tx_req !== 1'b0) begin
      errors++;
      $display("FAIL send_early: tx_req=%b after 2 cycles, want 0", tx_req);
    end
    @(negedge clock);
    checks++;
    if (tx_req !== 1'b1) begin
      errors++;
      $display("FAIL send_lat: tx_req=%b after 3 cycles, want 1", tx_req);
    end
    type_key(8'h7a);
    checks++;
    if (message_out !== e.msg || msg_len !== 5'd2) begin
      errors++;
      $display("FAIL send_frozen: msg=%h len=%0d, want msg=%h len=2",
               message_out, msg_len, e.msg);
    end
    send = 1'b0;
    @(negedge clock);
    tx_done = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (tx_req !== 1'b0 || msg_len !== 5'd0 || message_out !== '0) begin
      errors++;
      $display("FAIL done_clear: tx_req=%b len=%0d msg=%h, want 0/0/0",
               tx_req, msg_len, message_out);
    end
    tx_done = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL done_noerr: tx_error pulses=%0d, want 0", err_cnt - e0);
    end
    model_clear();
  endtask

  task automatic test_timeout();
    exp_t e;
    int e0, n, hi;
    do_reset();
    type_key(8'h78);
    model_key(8'h78);
    e = sb.pop_front();
    e0 = err_cnt;
    @(negedge clock);
    send = 1'b1;
    n = 0;
    while (tx_req !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (tx_req !== 1'b1) begin
      errors++;
      $display("FAIL to_start: tx_req=%b after %0d cycles, want 1", tx_req, n);
    end
    hi = 0;
    while (tx_req === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clock);
    end
    checks++;
    if (hi !== TO) begin
      errors++;
      $display("FAIL to_width: tx_req high %0d cycles, want %0d", hi, TO);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL to_error: tx_error pulses=%0d, want 1", err_cnt - e0);
    end
    checks++;
    if (msg_len !== e.len || message_out !== e.msg) begin
      errors++;
      $display("FAIL to_retain: msg=%h len=%0d, want msg=%h len=%0d",
               message_out, msg_len, e.msg, e.len);
    end
    send = 1'b0;
    repeat (3) @(negedge clock);
    send = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (tx_req !== 1'b1) begin
      errors++;
      $display("FAIL resend: tx_req=%b, want 1", tx_req);
    end
  endtask

  task automatic test_reset_in_send();
    send = 1'b0;
    do_reset();
    checks++;
    if (tx_req !== 1'b0 || msg_len !== 5'd0 || message_out !== '0) begin
      errors++;
      $display("FAIL rst_send: tx_req=%b len=%0d msg=%h, want 0/0/0",
               tx_req, msg_len, message_out);
    end
    send = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (tx_req !== 1'b0) begin
      errors++;
      $display("FAIL empty_send: tx_req=%b, want 0", tx_req);
    end
    send = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_hi();
    test_delete();
    test_overflow();
    test_send_done();
    test_timeout();
    test_reset_in_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
